// File: rtl/cpu_io_bridge.sv
// Purpose: device-side endpoint of the CPU IN/OUT port pair. It holds one
//   input FIFO (host to CPU) and one output FIFO (CPU to host).
// Latency: a word written at edge N appears at the FIFO head from N+1. There
//   is no same-cycle fall-through.
// Backpressure: host_in_ready is low while the input FIFO is full. A CPU OUT
//   into a full output FIFO with no drain in the same cycle is dropped and
//   flagged.
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   host_in_*                       host push side of the input FIFO (valid/ready)
//   cpu_in, cpu_in_valid, cpu_in_rd CPU IN port; cpu_in_rd is a one-cycle pulse
//   cpu_out_data, cpu_out_we        CPU OUT port; cpu_out_we is a one-cycle pulse
//   host_out_*                      host drain side of the output FIFO (valid/ready)
//   clr_err, err_underflow/overflow sticky error flags and their clear
//   in_count, out_count             FIFO occupancy
module cpu_io_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [DATA_WIDTH-1:0] cpu_in,
  output logic                  cpu_in_valid,
  input  logic                  cpu_in_rd,
  input  logic [DATA_WIDTH-1:0] cpu_out_data,
  input  logic                  cpu_out_we,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  input  logic                  clr_err,
  output logic                  err_underflow,
  output logic                  err_overflow,
  output logic [CNT_WIDTH-1:0]  in_count,
  output logic [CNT_WIDTH-1:0]  out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] in_mem_q  [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] out_mem_q [0:DEPTH-1];
  logic [PTR_W-1:0]      in_wp_q, in_rp_q, out_wp_q, out_rp_q;
  logic [CNT_WIDTH-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  err_unf_q, err_unf_d, err_ovf_q, err_ovf_d;

  logic in_full, in_empty, in_push, in_pop, unf_set;
  logic out_full, out_empty, out_push, out_drain, ovf_set;

  always_comb begin
    in_full   = (in_cnt_q == FULL_CNT);
    in_empty  = (in_cnt_q == '0);
    in_push   = host_in_valid && !in_full;
    in_pop    = cpu_in_rd && !in_empty;
    unf_set   = cpu_in_rd && in_empty;

    out_full  = (out_cnt_q == FULL_CNT);
    out_empty = (out_cnt_q == '0);
    out_drain = !out_empty && host_out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    out_push  = cpu_out_we && (!out_full || out_drain);
    ovf_set   = cpu_out_we && !out_push;

    in_cnt_d = in_cnt_q;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + CNT_ONE;
      2'b01:   in_cnt_d = in_cnt_q - CNT_ONE;
      default: in_cnt_d = in_cnt_q;
    endcase

    out_cnt_d = out_cnt_q;
    case ({out_push, out_drain})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase

    // A new error event wins over a clear in the same cycle.
    err_unf_d = unf_set || (err_unf_q && !clr_err);
    err_ovf_d = ovf_set || (err_ovf_q && !clr_err);
  end

  // Storage is not reset; emptiness is tracked by the counts alone.
  always_ff @(posedge clk) begin
    if (!rst && in_push)  in_mem_q[in_wp_q]   <= host_in_data;
    if (!rst && out_push) out_mem_q[out_wp_q] <= cpu_out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wp_q   <= '0;
      in_rp_q   <= '0;
      in_cnt_q  <= '0;
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
      hold_q    <= '0;
      err_unf_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (in_push)   in_wp_q  <= in_wp_q + PTR_ONE;
      if (in_pop) begin
        in_rp_q <= in_rp_q + PTR_ONE;
        hold_q  <= in_mem_q[in_rp_q];
      end
      if (out_push)  out_wp_q <= out_wp_q + PTR_ONE;
      if (out_drain) out_rp_q <= out_rp_q + PTR_ONE;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_unf_q <= err_unf_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // All status outputs come from registered counts, never from same-cycle
  // valid/ready inputs.
  assign host_in_ready  = !in_full;
  assign cpu_in_valid   = !in_empty;
  assign cpu_in         = in_empty ? hold_q : in_mem_q[in_rp_q];
  assign host_out_valid = !out_empty;
  assign host_out_data  = out_empty ? '0 : out_mem_q[out_rp_q];
  assign err_underflow  = err_unf_q;
  assign err_overflow   = err_ovf_q;
  assign in_count       = in_cnt_q;
  assign out_count      = out_cnt_q;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Purpose: self-checking bench for cpu_io_bridge, using directed scenarios
//   plus a randomized run checked against a queue-based reference model.
// Latency: inputs are driven 1 time unit after a rising edge, and outputs are
//   checked 1 time unit after the following edge.
// Backpressure: the model reproduces the ready/full/drop rules with queues.
module tb_cpu_io_bridge;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] host_in_data;
  logic          host_in_valid;
  logic          host_in_ready;
  logic [DW-1:0] cpu_in;
  logic          cpu_in_valid;
  logic          cpu_in_rd;
  logic [DW-1:0] cpu_out_data;
  logic          cpu_out_we;
  logic [DW-1:0] host_out_data;
  logic          host_out_valid;
  logic          host_out_ready;
  logic          clr_err;
  logic          err_underflow;
  logic          err_overflow;
  logic [CW-1:0] in_count;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] m_in[$];
  logic [DW-1:0] m_out[$];
  logic [DW-1:0] m_hold;
  logic          m_unf, m_ovf;

  cpu_io_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .cpu_in(cpu_in), .cpu_in_valid(cpu_in_valid), .cpu_in_rd(cpu_in_rd),
    .cpu_out_data(cpu_out_data), .cpu_out_we(cpu_out_we),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .clr_err(clr_err), .err_underflow(err_underflow), .err_overflow(err_overflow),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    host_in_valid  = 1'b0;
    host_in_data   = '0;
    cpu_in_rd      = 1'b0;
    cpu_out_we     = 1'b0;
    cpu_out_data   = '0;
    host_out_ready = 1'b0;
    clr_err        = 1'b0;
  endtask

  // Apply the current inputs to the model, then advance the DUT one edge.
  task automatic cyc();
    bit in_acc, in_take, unf, out_dr, out_acc, ovf;
    if (rst) begin
      m_in.delete();
      m_out.delete();
      m_hold = '0;
      m_unf  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      in_acc  = host_in_valid && (m_in.size() < DEPTH);
      in_take = cpu_in_rd && (m_in.size() > 0);
      unf     = cpu_in_rd && (m_in.size() == 0);
      out_dr  = host_out_ready && (m_out.size() > 0);
      out_acc = cpu_out_we && ((m_out.size() < DEPTH) || out_dr);
      ovf     = cpu_out_we && !out_acc;
      if (in_take) m_hold = m_in.pop_front();
      if (in_acc)  m_in.push_back(host_in_data);
      if (out_dr)  void'(m_out.pop_front());
      if (out_acc) m_out.push_back(cpu_out_data);
      m_unf = unf || (m_unf && !clr_err);
      m_ovf = ovf || (m_ovf && !clr_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    n_checks++; if (host_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset host_in_ready got %b exp 1", host_in_ready); end
    n_checks++; if (cpu_in !== 16'h0) begin n_fail++; $display("FAIL reset cpu_in got %h exp 0000", cpu_in); end
    n_checks++; if (cpu_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset cpu_in_valid got %b exp 0", cpu_in_valid); end
    n_checks++; if (host_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset host_out_valid got %b exp 0", host_out_valid); end
    n_checks++; if (host_out_data !== 16'h0) begin n_fail++; $display("FAIL reset host_out_data got %h exp 0000", host_out_data); end
    n_checks++; if (in_count !== 3'd0 || out_count !== 3'd0) begin n_fail++; $display("FAIL reset counts got %0d/%0d exp 0/0", in_count, out_count); end
    n_checks++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset errs got %b%b exp 00", err_underflow, err_overflow); end
  endtask

  task automatic test_in_basic();
    host_in_valid = 1'b1; host_in_data = 16'h0009;
    cyc();
    n_checks++; if (cpu_in !== 16'h0009 || cpu_in_valid !== 1'b1) begin n_fail++; $display("FAIL in_first got %h v%b exp 0009 v1", cpu_in, cpu_in_valid); end
    host_in_data = 16'h00A5;
    cyc();
    host_in_valid = 1'b0;
    n_checks++; if (in_count !== 3'd2) begin n_fail++; $display("FAIL in_count2 got %0d exp 2", in_count); end
    cpu_in_rd = 1'b1;
    cyc();
    n_checks++; if (cpu_in !== 16'h00A5) begin n_fail++; $display("FAIL in_second got %h exp 00a5", cpu_in); end
    cyc();
    cpu_in_rd = 1'b0;
    n_checks++; if (cpu_in_valid !== 1'b0 || cpu_in !== 16'h00A5 || in_count !== 3'd0) begin
      n_fail++; $display("FAIL in_hold got %h v%b c%0d exp 00a5 v0 c0", cpu_in, cpu_in_valid, in_count);
    end
  endtask

  task automatic test_in_full();
    host_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      host_in_data = DW'(i);
      cyc();
    end
    n_checks++; if (host_in_ready !== 1'b0 || in_count !== 3'd4) begin n_fail++; $display("FAIL in_full got rdy%b c%0d exp rdy0 c4", host_in_ready, in_count); end
    host_in_data = 16'h0005;
    cyc();
    host_in_valid = 1'b0;
    n_checks++; if (in_count !== 3'd4 || cpu_in !== 16'h0001) begin n_fail++; $display("FAIL in_5th got c%0d head %h exp c4 head 0001", in_count, cpu_in); end
    cpu_in_rd = 1'b1;
    cyc();
    cpu_in_rd = 1'b0;
    n_checks++; if (host_in_ready !== 1'b1 || in_count !== 3'd3) begin n_fail++; $display("FAIL in_after_pop got rdy%b c%0d exp rdy1 c3", host_in_ready, in_count); end
    for (int i = 2; i <= 4; i++) begin
      n_checks++; if (cpu_in !== DW'(i)) begin n_fail++; $display("FAIL in_order got %h exp %h", cpu_in, DW'(i)); end
      cpu_in_rd = 1'b1;
      cyc();
      cpu_in_rd = 1'b0;
    end
    n_checks++; if (cpu_in_valid !== 1'b0 || cpu_in !== 16'h0004) begin n_fail++; $display("FAIL in_drained got %h v%b exp 0004 v0", cpu_in, cpu_in_valid); end
  endtask

  task automatic test_underflow();
    cpu_in_rd = 1'b1;
    cyc();
    n_checks++; if (err_underflow !== 1'b1 || in_count !== 3'd0 || out_count !== 3'd0) begin
      n_fail++; $display("FAIL underflow got e%b c%0d/%0d exp e1 c0/0", err_underflow, in_count, out_count);
    end
    clr_err = 1'b1;
    cyc();
    n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set_priority got %b exp 1", err_underflow); end
    cpu_in_rd = 1'b0;
    cyc();
    clr_err = 1'b0;
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", err_underflow); end
  endtask

  task automatic test_overflow();
    host_out_ready = 1'b0;
    cpu_out_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_out_data = DW'(16'h10 + i);
      cyc();
    end
    cpu_out_we = 1'b0;
    n_checks++; if (out_count !== 3'd4 || err_overflow !== 1'b1 || host_out_data !== 16'h0010) begin
      n_fail++; $display("FAIL overflow got c%0d e%b head %h exp c4 e1 head 0010", out_count, err_overflow, host_out_data);
    end
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", err_overflow); end
    host_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (host_out_valid !== 1'b1 || host_out_data !== DW'(16'h10 + i)) begin
        n_fail++; $display("FAIL out_drain got v%b %h exp v1 %h", host_out_valid, host_out_data, DW'(16'h10 + i));
      end
      cyc();
    end
    host_out_ready = 1'b0;
    n_checks++; if (host_out_valid !== 1'b0 || host_out_data !== 16'h0 || out_count !== 3'd0) begin
      n_fail++; $display("FAIL out_empty got v%b %h c%0d exp v0 0000 c0", host_out_valid, host_out_data, out_count);
    end
  endtask

  task automatic test_full_drain();
    logic [DW-1:0] exp_seq [4];
    exp_seq = '{16'h11, 16'h12, 16'h13, 16'h20};
    cpu_out_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_out_data = DW'(16'h10 + i);
      cyc();
    end
    cpu_out_data = 16'h0020;
    host_out_ready = 1'b1;
    cyc();
    cpu_out_we = 1'b0;
    n_checks++; if (out_count !== 3'd4 || err_overflow !== 1'b0 || host_out_data !== 16'h0011) begin
      n_fail++; $display("FAIL full_drain got c%0d e%b head %h exp c4 e0 head 0011", out_count, err_overflow, host_out_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (host_out_data !== exp_seq[i]) begin n_fail++; $display("FAIL fd_order got %h exp %h", host_out_data, exp_seq[i]); end
      cyc();
    end
    host_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    host_in_valid = 1'b1; cpu_out_we = 1'b1;
    host_in_data = 16'hBEEF; cpu_out_data = 16'hDEAD;
    cyc();
    host_in_data = 16'hCAFE; cpu_out_data = 16'hF00D;
    cyc();
    idle();
    rst = 1'b1;
    host_in_valid = 1'b1; host_in_data = 16'h1234;
    cyc();
    rst = 1'b0;
    idle();
    n_checks++; if (host_in_ready !== 1'b1 || cpu_in_valid !== 1'b0 || cpu_in !== 16'h0) begin
      n_fail++; $display("FAIL rst_mid_in got rdy%b v%b %h exp rdy1 v0 0000", host_in_ready, cpu_in_valid, cpu_in);
    end
    n_checks++; if (host_out_valid !== 1'b0 || host_out_data !== 16'h0 || in_count !== 3'd0 || out_count !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_out got v%b %h c%0d/%0d exp v0 0000 c0/0", host_out_valid, host_out_data, in_count, out_count);
    end
    host_in_valid = 1'b1; host_in_data = 16'h0077;
    cpu_out_we = 1'b1; cpu_out_data = 16'h0055;
    cyc();
    idle();
    n_checks++; if (cpu_in !== 16'h0077 || host_out_data !== 16'h0055 || in_count !== 3'd1 || out_count !== 3'd1) begin
      n_fail++; $display("FAIL rst_mid_new got %h %h c%0d/%0d exp 0077 0055 c1/1", cpu_in, host_out_data, in_count, out_count);
    end
    cpu_in_rd = 1'b1; host_out_ready = 1'b1;
    cyc();
    idle();
    n_checks++; if (cpu_in !== 16'h0077 || cpu_in_valid !== 1'b0 || host_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_drain got %h v%b ov%b exp 0077 v0 ov0", cpu_in, cpu_in_valid, host_out_valid);
    end
  endtask

  task automatic test_random();
    int phase;
    logic [DW-1:0] e_cpu_in, e_out;
    for (int c = 0; c < 3000; c++) begin
      phase = (c / 150) % 3;   // 0: fill-heavy, 1: drain-heavy, 2: balanced
      rst            = ($urandom_range(0, 199) == 0);
      host_in_valid  = ($urandom_range(0, 3) < (phase == 1 ? 1 : 3));
      host_in_data   = DW'($urandom);
      cpu_in_rd      = ($urandom_range(0, 3) < (phase == 0 ? 1 : 3));
      cpu_out_we     = ($urandom_range(0, 3) < (phase == 1 ? 1 : 3));
      cpu_out_data   = DW'($urandom);
      host_out_ready = ($urandom_range(0, 3) < (phase == 0 ? 1 : 3));
      clr_err        = ($urandom_range(0, 15) == 0);
      cyc();
      e_cpu_in = (m_in.size() > 0) ? m_in[0] : m_hold;
      e_out    = (m_out.size() > 0) ? m_out[0] : '0;
      n_checks++; if (cpu_in !== e_cpu_in) begin n_fail++; $display("FAIL rnd cpu_in c%0d got %h exp %h", c, cpu_in, e_cpu_in); end
      n_checks++; if (cpu_in_valid !== (m_in.size() > 0)) begin n_fail++; $display("FAIL rnd cpu_in_valid c%0d got %b", c, cpu_in_valid); end
      n_checks++; if (host_in_ready !== (m_in.size() < DEPTH)) begin n_fail++; $display("FAIL rnd host_in_ready c%0d got %b", c, host_in_ready); end
      n_checks++; if (in_count !== CW'(m_in.size())) begin n_fail++; $display("FAIL rnd in_count c%0d got %0d exp %0d", c, in_count, m_in.size()); end
      n_checks++; if (host_out_data !== e_out) begin n_fail++; $display("FAIL rnd host_out_data c%0d got %h exp %h", c, host_out_data, e_out); end
      n_checks++; if (host_out_valid !== (m_out.size() > 0)) begin n_fail++; $display("FAIL rnd host_out_valid c%0d got %b", c, host_out_valid); end
      n_checks++; if (out_count !== CW'(m_out.size())) begin n_fail++; $display("FAIL rnd out_count c%0d got %0d exp %0d", c, out_count, m_out.size()); end
      n_checks++; if (err_underflow !== m_unf) begin n_fail++; $display("FAIL rnd err_underflow c%0d got %b exp %b", c, err_underflow, m_unf); end
      n_checks++; if (err_overflow !== m_ovf) begin n_fail++; $display("FAIL rnd err_overflow c%0d got %b exp %b", c, err_overflow, m_ovf); end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_hold = '0;
    m_unf  = 1'b0;
    m_ovf  = 1'b0;
    #1;
    test_reset();
    test_in_basic();
    test_in_full();
    test_underflow();
    test_overflow();
    test_full_drain();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
